// File: rtl/dpe_egress_sink_if.sv
`default_nettype none
// ============================================================================
// Module   : dpe_egress_sink_if
// Brief    : AXI-Stream beat bundle with tuser source/destination sideband.
// Revision : 1.0
// ============================================================================
interface dpe_egress_sink_if #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    parameter int ADDR_W = 3
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic [ADDR_W-1:0] tuser_src;
    logic [ADDR_W-1:0] tuser_dst;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser_src, tuser_dst,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser_src, tuser_dst,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/dpe_egress_sink.sv
`default_nettype none
// ============================================================================
// Module   : dpe_egress_sink
// Brief    : Store-and-forward egress receiver; forwards whole packets only and
//            drops packets that do not fit instead of stalling the DPE.
// Revision : 1.0
// ============================================================================
module dpe_egress_sink #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dpe_egress_sink_if.slave     s_axis,
    dpe_egress_sink_if.master    m_axis,
    output logic [CNT_W-1:0]     pkt_cnt,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 is_idle
);
    localparam int c_AW     = $clog2(DEPTH);
    localparam int c_PW     = c_AW + 1;
    localparam int c_WORD_W = DATA_W + KEEP_W + 1 + 2 * ADDR_W;
    localparam logic [c_PW-1:0]  c_PTR_DEPTH = c_PW'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [c_PW-1:0]     r_wr_ptr;
    logic [c_PW-1:0]     r_commit_ptr;
    logic [c_PW-1:0]     r_rd_ptr;
    logic [c_WORD_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]    r_pkt_cnt;
    logic [CNT_W-1:0]    r_drop_cnt;

    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [KEEP_W-1:0] r_m_keep;
    logic              r_m_last;
    logic [ADDR_W-1:0] r_m_src;
    logic [ADDR_W-1:0] r_m_dst;
    logic              r_rd_first;

    logic                w_s_acc;
    logic                w_full;
    logic                w_empty;
    logic                w_wr_en;
    logic                w_commit;
    logic                w_drop;
    logic                w_load;
    logic [c_WORD_W-1:0] w_rd_word;

    assign s_axis.tready = rst_n;
    assign w_s_acc = s_axis.tvalid && s_axis.tready;
    // Space is judged against the registered read pointer only.
    assign w_full  = (r_wr_ptr - r_rd_ptr) == c_PTR_DEPTH;
    assign w_empty = (r_rd_ptr == r_commit_ptr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        if (w_s_acc) begin
            unique case (r_state)
                ST_IDLE, ST_STORE: begin
                    if (!w_full) begin
                        w_wr_en     = 1'b1;
                        w_commit    = s_axis.tlast;
                        w_state_nxt = s_axis.tlast ? ST_IDLE : ST_STORE;
                    end else begin
                        w_drop      = 1'b1;
                        w_state_nxt = s_axis.tlast ? ST_IDLE : ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (s_axis.tlast) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // A drop rewinds to the last commit; in IDLE the two pointers already match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_pkt_cnt    <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end else if (w_drop) begin
                r_wr_ptr <= r_commit_ptr;
            end
            if (w_commit) begin
                r_commit_ptr <= r_wr_ptr + 1'b1;
                if (r_pkt_cnt != c_CNT_MAX) begin
                    r_pkt_cnt <= r_pkt_cnt + 1'b1;
                end
            end
            if (w_drop && (r_drop_cnt != c_CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {s_axis.tdata, s_axis.tkeep, s_axis.tlast,
                                          s_axis.tuser_src, s_axis.tuser_dst};
        end
    end

    assign w_rd_word = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_load    = !w_empty && (!r_m_valid || m_axis.tready);

    // Sideband is latched only on the first beat so it stays constant per packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_keep   <= '0;
            r_m_last   <= 1'b0;
            r_m_src    <= '0;
            r_m_dst    <= '0;
            r_rd_first <= 1'b1;
        end else if (w_load) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_m_valid  <= 1'b1;
            r_m_data   <= w_rd_word[c_WORD_W-1 -: DATA_W];
            r_m_keep   <= w_rd_word[2*ADDR_W+1 +: KEEP_W];
            r_m_last   <= w_rd_word[2*ADDR_W];
            r_rd_first <= w_rd_word[2*ADDR_W];
            if (r_rd_first) begin
                r_m_src <= w_rd_word[ADDR_W +: ADDR_W];
                r_m_dst <= w_rd_word[0 +: ADDR_W];
            end
        end else if (m_axis.tready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_axis.tvalid    = r_m_valid;
    assign m_axis.tdata     = r_m_data;
    assign m_axis.tkeep     = r_m_keep;
    assign m_axis.tlast     = r_m_last;
    assign m_axis.tuser_src = r_m_src;
    assign m_axis.tuser_dst = r_m_dst;

    assign pkt_cnt  = r_pkt_cnt;
    assign drop_cnt = r_drop_cnt;
    assign is_idle  = w_empty && (r_state == ST_IDLE);
endmodule
`default_nettype wire
